// File: rtl/slt_pkg.sv
// -----------------------------------------------------------------------------
// slt_pkg
// Shared definitions for the set-less-than compare block and the ALU that
// reuses it:
//   DEFAULT_WIDTH              default operand width in bits
//   CMP_SIGNED / CMP_UNSIGNED  encoding of the is_unsigned mode input
//   cmp_flags_t                (lt, eq) pair produced by every compare cell
//   nibble_cmp / merge_flags   leaf cell and tree merge used by ult_cmp
//   nibble_count / pow2_ceil   elaboration-time sizing helpers
// -----------------------------------------------------------------------------
package slt_pkg;

  localparam int DEFAULT_WIDTH = 64;

  // Mode encoding on the is_unsigned pin.
  localparam logic CMP_SIGNED   = 1'b0;
  localparam logic CMP_UNSIGNED = 1'b1;

  // Operands are split into 4-bit digits for the leaf compare cells.
  localparam int NIBBLE_W = 4;

  // Result of comparing two equal-width slices: lt = (a < b), eq = (a == b).
  typedef struct packed {
    logic lt;
    logic eq;
  } cmp_flags_t;

  // Number of 4-bit digits needed to cover 'width' bits.
  function automatic int nibble_count(input int width);
    return (width + NIBBLE_W - 1) / NIBBLE_W;
  endfunction

  // Smallest power of two that is >= n (n >= 1).
  function automatic int pow2_ceil(input int n);
    int p;
    p = 1;
    for (int i = 0; i < 31; i++) begin
      if (p < n) begin
        p = p * 2;
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

  // Leaf cell: unsigned compare of one 4-bit digit pair.
  function automatic cmp_flags_t nibble_cmp(input logic [3:0] x, input logic [3:0] z);
    cmp_flags_t f;
    f.lt = (x < z);
    f.eq = (x == z);
    return f;
  endfunction

  // Merge two adjacent slices, 'hi' being the more significant one.
  // The high slice decides unless it is equal, in which case the low slice
  // decides; the pair is equal only if both halves are equal.
  function automatic cmp_flags_t merge_flags(input cmp_flags_t hi, input cmp_flags_t lo);
    cmp_flags_t f;
    f.lt = hi.lt | (hi.eq & lo.lt);
    f.eq = hi.eq & lo.eq;
    return f;
  endfunction

endpackage

// File: rtl/slt_ult_cmp.sv
// -----------------------------------------------------------------------------
// ult_cmp
// Unsigned less-than / equal comparator for WIDTH-bit operands. The operands
// are zero-extended to a power-of-two number of 4-bit digits, each digit pair
// is compared by a small leaf cell, and the digit results are merged pairwise
// MSB-first in a balanced tree, so depth grows with log2(WIDTH).
// Ports:
//   a, b  input  [WIDTH-1:0]  operands, unsigned magnitudes
//   lt    output 1            1 when a < b
//   eq    output 1            1 when a == b
// -----------------------------------------------------------------------------
module ult_cmp
  import slt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             eq
);

  localparam int NNIB   = nibble_count(WIDTH);
  localparam int NLEAF  = pow2_ceil(NNIB);
  localparam int LEVELS = $clog2(NLEAF);
  localparam int PW     = NLEAF * NIBBLE_W;

  // Zero padding on the MSB side compares equal, so it never changes the
  // verdict of the real bits.
  logic [PW-1:0] a_ext_s;
  logic [PW-1:0] b_ext_s;

  assign a_ext_s = PW'(a);
  assign b_ext_s = PW'(b);

  // Leaf results, index 0 is the least significant digit.
  cmp_flags_t leaf_s [NLEAF];

  for (genvar i = 0; i < NLEAF; i++) begin : g_leaf
    assign leaf_s[i] = nibble_cmp(a_ext_s[i*NIBBLE_W +: NIBBLE_W],
                                  b_ext_s[i*NIBBLE_W +: NIBBLE_W]);
  end

  // Working array for the reduction; after the last level entry 0 holds the
  // verdict for the whole operand.
  cmp_flags_t node_s [NLEAF];

  // Balanced merge tree: each level halves the number of live slices.
  // In-place update is safe because entry k only reads entries 2k and 2k+1,
  // which are never below k.
  always_comb begin
    node_s = leaf_s;
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      for (int k = 0; k < NLEAF; k++) begin
        if (k < (NLEAF >> (lvl + 1))) begin
          node_s[k] = merge_flags(node_s[2*k+1], node_s[2*k]);
        end else begin
          node_s[k] = node_s[k];
        end
      end
    end
    lt = node_s[0].lt;
    eq = node_s[0].eq;
  end

endmodule

// File: rtl/slt.sv
// -----------------------------------------------------------------------------
// slt
// Set-less-than for signed (SLT) and unsigned (SLTU) operands. The compare
// itself is combinational (y); a registered copy (y_q) and a valid strobe
// (out_valid) follow one cycle after each accepted in_valid. Every cycle can
// carry a new operand pair; there is no backpressure.
// Ports:
//   clk          input  1          rising-edge clock
//   rst          input  1          synchronous active-high reset
//   a, b         input  [WIDTH-1:0] operands (two's complement in signed mode)
//   is_unsigned  input  1          CMP_SIGNED (0) or CMP_UNSIGNED (1)
//   in_valid     input  1          qualifies a/b/is_unsigned for y_q
//   y            output 1          combinational a < b
//   y_q          output 1          y captured on an in_valid cycle
//   out_valid    output 1          high the cycle after an accepted in_valid
// -----------------------------------------------------------------------------
module slt
  import slt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_unsigned,
  input  logic             in_valid,
  output logic             y,
  output logic             y_q,
  output logic             out_valid
);

  logic mag_lt_s;
  logic mag_eq_s;
  logic sign_diff_s;
  logic lt_sel_s;
  logic y_q_r;
  logic out_valid_r;

  // Full-width unsigned magnitude compare shared by both modes.
  ult_cmp #(
    .WIDTH (WIDTH)
  ) u_ult_cmp (
    .a  (a),
    .b  (b),
    .lt (mag_lt_s),
    .eq (mag_eq_s)
  );

  // Mode selection. In signed mode, operands with different sign bits are
  // ordered by the sign alone (the negative one is smaller). With equal sign
  // bits the MSBs cancel, so the full-width unsigned verdict equals the
  // verdict on the remaining bits, for negatives as well as positives.
  always_comb begin
    sign_diff_s = a[WIDTH-1] ^ b[WIDTH-1];
    lt_sel_s    = 1'b0;
    case (is_unsigned)
      CMP_SIGNED: begin
        if (sign_diff_s) begin
          lt_sel_s = a[WIDTH-1];
        end else begin
          lt_sel_s = mag_lt_s;
        end
      end
      CMP_UNSIGNED: begin
        lt_sel_s = mag_lt_s;
      end
      default: begin
        lt_sel_s = 1'b0;
      end
    endcase
    // Equal operands can never be "less than", whatever the mode.
    y = lt_sel_s & ~mag_eq_s;
  end

  // Output register: reset wins over in_valid; y_q holds between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (in_valid) begin
      y_q_r       <= y;
      out_valid_r <= 1'b1;
    end else begin
      y_q_r       <= y_q_r;
      out_valid_r <= 1'b0;
    end
  end

  assign y_q       = y_q_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_slt.sv
// -----------------------------------------------------------------------------
// tb_slt
// Self-checking bench for slt at WIDTH = 64. Inputs change on the falling
// edge; y is sampled 1 ns later and y_q/out_valid 1 ns after the rising edge.
// Expected registered results are queued when an accepted in_valid is driven
// and popped when the output is due.
// -----------------------------------------------------------------------------
module tb_slt;

  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         is_unsigned;
  logic         in_valid;
  logic         y;
  logic         y_q;
  logic         out_valid;

  int   total;
  int   bad;
  logic exp_hold;
  logic sb [$];

  localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] MNEG = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] MPOS = 64'h7FFF_FFFF_FFFF_FFFF;

  slt #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .is_unsigned (is_unsigned),
    .in_valid    (in_valid),
    .y           (y),
    .y_q         (y_q),
    .out_valid   (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain SystemVerilog relational operators.
  function automatic logic ref_lt(input logic [W-1:0] x, input logic [W-1:0] z, input logic m);
    if (m) return (x < z);
    else   return ($signed(x) < $signed(z));
  endfunction

  // Random operand with a bias towards the corner values.
  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return ONES;
      3: return MNEG;
      4: return MPOS;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic drive(input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic m, input logic v, input logic r);
    @(negedge clk);
    a = xa; b = xb; is_unsigned = m; in_valid = v; rst = r;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(64'd10, 64'd20, 1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
      total++;
      if (y_q !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset: y_q=%b out_valid=%b, want 0 0", y_q, out_valid);
      end
    end
    drive(64'd10, 64'd20, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    total++;
    if (y_q !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: y_q=%b out_valid=%b, want 0 0", y_q, out_valid);
    end
    exp_hold = 1'b0;
  endtask

  task automatic test_compare();
    logic [W-1:0] ta [11];
    logic [W-1:0] tb [11];
    logic         tm [11];
    logic         te [11];
    logic         e;
    ta = '{64'd10, 64'hFFFF_FFFF_FFFF_FFFB, 64'd100, ONES, ONES, ONES,
           MNEG, MNEG, 64'd100, MPOS, 64'd0};
    tb = '{64'd20, 64'd0, 64'd100, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'd1,
           MPOS, MPOS, 64'd100, MNEG, ONES};
    tm = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    te = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 11; i++) begin
      drive(ta[i], tb[i], tm[i], 1'b1, 1'b0);
      total++;
      if (y !== te[i]) begin
        bad++;
        $display("FAIL compare_y[%0d]: a=%h b=%h u=%b y=%b, want %b", i, ta[i], tb[i], tm[i], y, te[i]);
      end
      sb.push_back(te[i]);
      @(posedge clk); #1;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL compare_sb[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        exp_hold = e;
        if (y_q !== e || out_valid !== 1'b1) begin
          bad++;
          $display("FAIL compare_q[%0d]: y_q=%b out_valid=%b, want %b 1", i, y_q, out_valid, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] sa [3];
    logic [W-1:0] sbv [3];
    logic         se [3];
    logic         e;
    sa  = '{64'd10, 64'd20, 64'd5};
    sbv = '{64'd20, 64'd10, 64'd5};
    se  = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(sa[i], sbv[i], 1'b0, 1'b1, 1'b0);
      sb.push_back(se[i]);
      @(posedge clk); #1;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL stream_sb[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        exp_hold = e;
        if (y_q !== e || out_valid !== 1'b1) begin
          bad++;
          $display("FAIL stream[%0d]: y_q=%b out_valid=%b, want %b 1", i, y_q, out_valid, e);
        end
      end
    end
    drive(64'd1, 64'd2, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    total++;
    if (y_q !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stream_idle: y_q=%b out_valid=%b, want 0 0", y_q, out_valid);
    end
  endtask

  task automatic test_reset_override();
    drive(64'd10, 64'd20, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    total++;
    if (y_q !== 1'b1 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL ovr_pre: y_q=%b out_valid=%b, want 1 1", y_q, out_valid);
    end
    drive(64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b0, 1'b1, 1'b1);
    total++;
    if (y !== 1'b1) begin
      bad++;
      $display("FAIL ovr_y: y=%b, want 1", y);
    end
    @(posedge clk); #1;
    total++;
    if (y_q !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ovr_q: y_q=%b out_valid=%b, want 0 0", y_q, out_valid);
    end
    drive(64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    total++;
    if (y_q !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ovr_after: y_q=%b out_valid=%b, want 0 0", y_q, out_valid);
    end
    exp_hold = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] xa;
    logic [W-1:0] xb;
    logic         m;
    logic         v;
    logic         e;
    for (int n = 0; n < 10000; n++) begin
      xa = pick();
      xb = pick();
      if ($urandom_range(0, 15) == 0) xb = xa;
      m = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 3) != 0);
      drive(xa, xb, m, v, 1'b0);
      e = ref_lt(xa, xb, m);
      total++;
      if (y !== e) begin
        bad++;
        $display("FAIL rand_y[%0d]: a=%h b=%h u=%b y=%b, want %b", n, xa, xb, m, y, e);
      end
      if (v) sb.push_back(e);
      @(posedge clk); #1;
      total++;
      if (v) begin
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL rand_sb[%0d]: scoreboard empty", n);
        end else begin
          exp_hold = sb.pop_front();
          if (y_q !== exp_hold || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL rand_q[%0d]: y_q=%b out_valid=%b, want %b 1", n, y_q, out_valid, exp_hold);
          end
        end
      end else if (y_q !== exp_hold || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL rand_hold[%0d]: y_q=%b out_valid=%b, want %b 0", n, y_q, out_valid, exp_hold);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_hold = 1'b0;
    rst = 1'b1;
    a = '0;
    b = '0;
    is_unsigned = 1'b0;
    in_valid = 1'b0;
    test_reset();
    test_compare();
    test_back_to_back();
    test_reset_override();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slt.md
SLT -- requirements
Module: slt

Interface
REQ-001 Parameter WIDTH, default 64, operand width in bits; SHALL support any value >= 2.
REQ-002 Clocking: one clock, clk; reset rst, synchronous, active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 a  input  WIDTH  left operand, two's complement when signed mode.
REQ-006 b  input  WIDTH  right operand, two's complement when signed mode.
REQ-007 is_unsigned  input  1  0 = signed compare (SLT), 1 = unsigned compare (SLTU).
REQ-008 in_valid  input  1  qualifies a/b/is_unsigned for the registered path.
REQ-009 y  output  1  combinational compare result, 1 when a < b.
REQ-010 y_q  output  1  registered copy of y captured on an in_valid cycle.
REQ-011 out_valid  output  1  high for the cycle after an accepted in_valid.

Function
REQ-012 y SHALL equal 1 iff a < b under the mode selected by is_unsigned, else 0; purely combinational, zero-cycle latency, independent of clk/rst.
REQ-013 Signed mode SHALL interpret a, b as two's complement: different MSBs -> y = a[MSB]; equal MSBs -> y = unsigned compare of the remaining bits.
REQ-014 Unsigned mode SHALL compare a, b as unsigned magnitudes.
REQ-015 a == b SHALL give y = 0 in both modes.
REQ-016 Result SHALL be exact for all corner operands: most-negative, most-positive, zero, all-ones; no overflow artefacts (no a - b sign shortcut without overflow correction).
REQ-017 On a rising clk with rst = 0 and in_valid = 1: y_q <= y, out_valid <= 1 (one-cycle latency).
REQ-018 On a rising clk with rst = 0 and in_valid = 0: y_q holds, out_valid <= 0.
REQ-019 Back-to-back in_valid SHALL be accepted every cycle; no backpressure, no stall.
REQ-020 No X propagation from y_q/out_valid once reset has been applied.

Reset
REQ-021 rst = 1 at a rising clk SHALL force y_q = 0 and out_valid = 0, overriding in_valid in the same cycle.
REQ-022 Reset asserted mid-stream SHALL drop the in-flight result; first result after reset requires a new in_valid.
REQ-023 y SHALL remain functional during reset (combinational).

Structure
REQ-024 Shared package SHALL hold the default WIDTH constant and the mode encoding constants (CMP_SIGNED = 0, CMP_UNSIGNED = 1) for reuse by the ALU.
REQ-025 One sub-module natural: ult_cmp, a WIDTH-parameterised unsigned less-than/equal comparator (tree of per-nibble lt/eq cells merged MSB-first); slt wraps it with sign handling and the output register.
REQ-026 No multiplier, no subtractor-based compare; the combinational depth SHALL be logarithmic in WIDTH.

Verification
REQ-027 Signed, a = 10, b = 20 -> y = 1; after in_valid and one clk, y_q = 1, out_valid = 1.
REQ-028 Signed, a = -5, b = 0 -> y = 1; a = 100, b = 100 -> y = 0; a = -1, b = -2 -> y = 0.
REQ-029 a = 0xFFFF_FFFF_FFFF_FFFF, b = 1: signed -> y = 1, unsigned -> y = 0; a = 0x8000_0000_0000_0000, b = 0x7FFF_FFFF_FFFF_FFFF: signed -> 1, unsigned -> 0.
REQ-030 Stream three in_valid cycles (10<20, 20<10, 5<5) -> y_q sequence 1, 0, 0 on consecutive cycles with out_valid high each cycle, then out_valid low with y_q holding 0.
REQ-031 rst asserted concurrently with in_valid (a = -5, b = 0) -> next cycle y_q = 0, out_valid = 0; y still 1 combinationally.
REQ-032 Randomised 10k-vector check of y and y_q against a signed/unsigned reference model in both modes.
